mem_port_arbiter: RTL and testbench

//   Shares the single-port data/instruction Memory between two requesters: instruction

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (read-only)
// and the load/store unit; one access in flight, fixed four-cycle IDLE/ISSUE/WAIT/RESP sequence.
module mem_port_arbiter #(
    parameter int  DATA_W    = 32,
    parameter int  MEM_DEPTH = 512,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // One extra bit so MEM_DEPTH itself is representable when it is a power of two.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    state_t state_reg;
    logic   last_ls_reg;
    logic   gnt_ls_reg;
    logic   oor_reg;

    logic              grant_ls;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic              req_in_range;

    // LS wins when it is the only requester, or when both ask and IF was served last.
    assign grant_ls     = ls_req && (!if_req || !last_ls_reg);
    assign req_addr     = grant_ls ? ls_addr : if_addr;
    assign req_we       = grant_ls && ls_we;
    assign req_in_range = ({1'b0, req_addr} < DEPTH_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            last_ls_reg <= 1'b1;
            gnt_ls_reg  <= 1'b0;
            oor_reg     <= 1'b0;
            if_ack      <= 1'b0;
            if_rdata    <= '0;
            if_err      <= 1'b0;
            ls_ack      <= 1'b0;
            ls_rdata    <= '0;
            ls_err      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (if_req || ls_req) begin
                        gnt_ls_reg  <= grant_ls;
                        last_ls_reg <= grant_ls;
                        oor_reg     <= !req_in_range;
                        mem_addr    <= req_addr;
                        mem_wdata   <= ls_wdata;
                        mem_we      <= req_we && req_in_range;
                        busy        <= 1'b1;
                        state_reg   <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_we    <= 1'b0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // Memory data is valid now; out-of-range accesses return zero.
                    if (gnt_ls_reg) begin
                        ls_ack   <= 1'b1;
                        ls_err   <= oor_reg;
                        ls_rdata <= oor_reg ? '0 : mem_rdata;
                    end else begin
                        if_ack   <= 1'b1;
                        if_err   <= oor_reg;
                        if_rdata <= oor_reg ? '0 : mem_rdata;
                    end
                    state_reg <= RESP;
                end
                RESP: begin
                    if_ack    <= 1'b0;
                    ls_ack    <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first single-port memory model
// (MEM_DEPTH=500 so out-of-range addresses exist).
module tb_mem_port_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 500;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_ack;
    logic [DW-1:0] ls_rdata;
    logic          ls_err;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    logic [DW-1:0] mem [0:511];
    logic [DW-1:0] snap [0:511];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DW), .MEM_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Write-first memory: a store reads back the word just written.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            mem_rdata     <= mem_wdata;
        end else begin
            mem_rdata <= mem[mem_addr];
        end
    end

    function automatic logic [DW-1:0] pat(input int i);
        return 32'hC0DE_0000 ^ (i * 32'h0000_0101);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({if_ack, ls_ack, if_err, ls_err, mem_we, busy} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 000000", {if_ack, ls_ack, if_err, ls_err, mem_we, busy});
        end
        vectors++;
        if ({if_rdata, ls_rdata, mem_wdata, mem_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got if_rdata=%h ls_rdata=%h mem_wdata=%h mem_addr=%0d want all 0",
                     if_rdata, ls_rdata, mem_wdata, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_store();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 9'd5; ls_wdata = 32'h0000_DEAD;
        for (int s = 1; s <= 4; s++) begin
            step();
            if (s == 3) ls_req = 1'b0;
            vectors++;
            if (mem_we !== (s == 1)) begin
                miscompares++;
                $display("FAIL store_mem_we cyc%0d: got %b want %b", s, mem_we, (s == 1));
            end
            vectors++;
            if (ls_ack !== (s == 3)) begin
                miscompares++;
                $display("FAIL store_ack cyc%0d: got %b want %b", s, ls_ack, (s == 3));
            end
            if (s == 1) begin
                vectors++;
                if (mem_addr !== 9'd5 || mem_wdata !== 32'h0000_DEAD) begin
                    miscompares++;
                    $display("FAIL store_issue: got addr=%0d wdata=%h want 5/0000dead", mem_addr, mem_wdata);
                end
            end
            if (s == 3) begin
                vectors++;
                if (ls_rdata !== 32'h0000_DEAD || ls_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL store_resp: got rdata=%h err=%b want 0000dead/0", ls_rdata, ls_err);
                end
            end
        end
        $display("store addr=5 wdata=0000dead: ls_rdata=%h ls_err=%b", ls_rdata, ls_err);
    endtask

    task automatic test_load();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 9'd5;
        for (int s = 1; s <= 4; s++) begin
            step();
            if (s == 3) ls_req = 1'b0;
            vectors++;
            if (if_ack !== 1'b0 || ls_ack !== (s == 3) || mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL load_ctrl cyc%0d: got if_ack=%b ls_ack=%b mem_we=%b want 0/%b/0",
                         s, if_ack, ls_ack, mem_we, (s == 3));
            end
            if (s == 3) begin
                vectors++;
                if (ls_rdata !== 32'h0000_DEAD || ls_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL load_data: got rdata=%h err=%b want 0000dead/0", ls_rdata, ls_err);
                end
            end
        end
        $display("load addr=5: ls_rdata=%h", ls_rdata);
    endtask

    // One LS access with expected err/data checked at the ack cycle.
    task automatic ls_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input logic exp_err, input logic [DW-1:0] exp_data, input string name);
        ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd;
        for (int s = 1; s <= 4; s++) begin
            step();
            if (s == 3) ls_req = 1'b0;
            vectors++;
            if (ls_ack !== (s == 3) || (we && !exp_err && s == 1) !== mem_we) begin
                miscompares++;
                $display("FAIL %s_ctrl cyc%0d: got ls_ack=%b mem_we=%b", name, s, ls_ack, mem_we);
            end
            if (s == 3) begin
                vectors++;
                if (ls_err !== exp_err || ls_rdata !== exp_data) begin
                    miscompares++;
                    $display("FAIL %s_resp: got err=%b rdata=%h want err=%b rdata=%h",
                             name, ls_err, ls_rdata, exp_err, exp_data);
                end
            end
        end
        $display("%s addr=%0d we=%b: err=%b rdata=%h", name, a, we, ls_err, ls_rdata);
    endtask

    task automatic test_out_of_range();
        int bad;
        for (int i = 0; i < 512; i++) snap[i] = mem[i];
        ls_access(1'b1, 9'd510, 32'h1234_5678, 1'b1, 32'h0, "oor_store");
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== snap[i]) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL oor_mem_unchanged: got %0d changed words want 0", bad);
        end
        ls_access(1'b0, 9'd499, 32'h0, 1'b0, pat(499), "edge_load");
        ls_access(1'b0, 9'd500, 32'h0, 1'b1, 32'h0, "oor_load");
    endtask

    task automatic test_reset_mid();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 9'd7; ls_wdata = 32'h0000_BEEF;
        step();
        step();
        if_req = 1'b1; if_addr = 9'd30;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({if_ack, ls_ack, if_err, ls_err, mem_we, busy} !== 6'b0 ||
            {if_rdata, ls_rdata, mem_wdata, mem_addr} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got ctrl=%b ls_rdata=%h mem_addr=%0d want all 0",
                     {if_ack, ls_ack, if_err, ls_err, mem_we, busy}, ls_rdata, mem_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (ls_ack !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_noack: got ls_ack=%b busy=%b want 0/0", ls_ack, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            step();
            if (s == 3) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
            if (s == 1) begin
                vectors++;
                if (mem_addr !== 9'd30 || mem_we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midreset_grant: got mem_addr=%0d mem_we=%b want 30/0", mem_addr, mem_we);
                end
            end
            vectors++;
            if (if_ack !== (s == 3) || ls_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_ack cyc%0d: got if_ack=%b ls_ack=%b want %b/0", s, if_ack, ls_ack, (s == 3));
            end
            if (s == 3) begin
                vectors++;
                if (if_rdata !== pat(30) || if_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midreset_data: got if_rdata=%h err=%b want %h/0", if_rdata, if_err, pat(30));
                end
            end
        end
        $display("reset in WAIT then both req: IF served first, if_rdata=%h", if_rdata);
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 9'd10;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 9'd20;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            step();
            if (c == 32) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
            vectors++;
            if (if_ack !== (c % 8 == 3) || ls_ack !== (c % 8 == 7)) begin
                miscompares++;
                $display("FAIL rr_ack cyc%0d: got if_ack=%b ls_ack=%b want %b/%b",
                         c, if_ack, ls_ack, (c % 8 == 3), (c % 8 == 7));
            end
            if (c % 8 == 3) begin
                vectors++;
                if (if_rdata !== pat(10)) begin
                    miscompares++;
                    $display("FAIL rr_if_data cyc%0d: got %h want %h", c, if_rdata, pat(10));
                end
            end
            if (c % 8 == 7) begin
                vectors++;
                if (ls_rdata !== pat(20)) begin
                    miscompares++;
                    $display("FAIL rr_ls_data cyc%0d: got %h want %h", c, ls_rdata, pat(20));
                end
            end
        end
        $display("round robin: 4 IF and 4 LS accesses alternated over 32 cycles");
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [4];
        addrs[0] = 9'd40; addrs[1] = 9'd41; addrs[2] = 9'd499; addrs[3] = 9'd0;
        if_req = 1'b1; if_addr = addrs[0];
        for (int k = 0; k < 4; k++) begin
            for (int s = 1; s <= 4; s++) begin
                step();
                vectors++;
                if (busy !== (s != 4) || if_ack !== (s == 3)) begin
                    miscompares++;
                    $display("FAIL b2b_ctrl acc%0d cyc%0d: got busy=%b if_ack=%b want %b/%b",
                             k, s, busy, if_ack, (s != 4), (s == 3));
                end
                if (s == 3) begin
                    vectors++;
                    if (if_rdata !== pat(int'(addrs[k])) || if_err !== 1'b0) begin
                        miscompares++;
                        $display("FAIL b2b_data acc%0d: got %h err=%b want %h/0",
                                 k, if_rdata, if_err, pat(int'(addrs[k])));
                    end
                    $display("b2b fetch addr=%0d: if_rdata=%h", addrs[k], if_rdata);
                    if (k < 3) if_addr = addrs[k + 1];
                    else if_req = 1'b0;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = pat(i);
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        test_reset();
        test_store();
        test_load();
        test_out_of_range();
        test_reset_mid();
        test_round_robin();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
